// File: rtl/ras_pkg.sv
// Shared types and helpers for the return-address-stack front end.
package ras_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    CALL  = 2'd1,
    RET   = 2'd2,
    CORET = 2'd3
  } kind_e;

  typedef enum logic {
    IDLE = 1'b0,
    SPEC = 1'b1
  } state_e;

  localparam int unsigned INSTR_BYTES_DEF = 4;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_ctrl.sv
// Drives push/pop/branch/close strobes for the return address stack and
// returns the predicted target one cycle after a return is accepted.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  kind_e                     instr_kind,
  input  logic                      instr_is_branch,
  input  logic [WIDTH-1:0]          instr_pc,
  input  logic                      resolve_valid,
  input  logic                      resolve_correct,
  output logic                      ras_push,
  output logic                      ras_pop,
  output logic                      ras_branch,
  output logic                      ras_close_valid,
  output logic                      ras_close_invalid,
  output logic [WIDTH-1:0]          ras_din,
  input  logic [WIDTH-1:0]          ras_dout,
  output logic                      pred_valid,
  output logic [WIDTH-1:0]          pred_target,
  output logic                      pred_empty,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int unsigned   OW      = occ_w(DEPTH);
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

  state_e        state_q, state_d;
  logic [OW-1:0] occ_q, occ_d, ckpt_q, ckpt_d, occ_instr;
  logic          pred_valid_q, pred_valid_d, pred_empty_q, pred_empty_d;
  logic          accept, occ_zero;

  always_comb begin
    instr_ready       = !resolve_valid && !(state_q == SPEC && instr_is_branch);
    accept            = instr_valid && instr_ready;
    occ_zero          = (occ_q == '0);
    ras_push          = 1'b0;
    ras_pop           = 1'b0;
    ras_branch        = 1'b0;
    ras_close_valid   = 1'b0;
    ras_close_invalid = 1'b0;
    pred_valid_d      = 1'b0;
    pred_empty_d      = 1'b0;
    occ_instr         = occ_q;
    state_d           = state_q;
    ckpt_d            = ckpt_q;

    if (accept) begin
      case (instr_kind)
        CALL: begin
          ras_push  = 1'b1;
          occ_instr = (occ_q == OCC_MAX) ? OCC_MAX : occ_q + OW'(1);
        end
        RET: begin
          ras_pop      = !occ_zero;
          occ_instr    = occ_zero ? occ_q : occ_q - OW'(1);
          pred_valid_d = 1'b1;
          pred_empty_d = occ_zero;
        end
        CORET: begin
          ras_push     = 1'b1;
          ras_pop      = 1'b1;
          occ_instr    = occ_zero ? OW'(1) : occ_q;
          pred_valid_d = 1'b1;
          pred_empty_d = occ_zero;
        end
        default: ;
      endcase
    end

    occ_d = occ_instr;

    // Accepting a branch implies IDLE; the checkpoint includes this
    // instruction's own push/pop so a rollback keeps it.
    if (accept && instr_is_branch) begin
      ras_branch = 1'b1;
      ckpt_d     = occ_instr;
      state_d    = SPEC;
    end

    if (state_q == SPEC && resolve_valid) begin
      state_d = IDLE;
      if (resolve_correct) begin
        ras_close_valid = 1'b1;
      end else begin
        ras_close_invalid = 1'b1;
        occ_d             = ckpt_q;
      end
    end

    ras_din     = ras_push ? instr_pc + WIDTH'(INSTR_BYTES) : '0;
    pred_valid  = pred_valid_q;
    pred_empty  = pred_empty_q;
    pred_target = pred_valid_q ? ras_dout : '0;
    occupancy   = occ_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      ckpt_q       <= '0;
      pred_valid_q <= 1'b0;
      pred_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      ckpt_q       <= ckpt_d;
      pred_valid_q <= pred_valid_d;
      pred_empty_q <= pred_empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(state_q == IDLE && resolve_valid))
        else $error("resolve_valid with no open speculative region");
      assert (!(ras_push && (ras_close_valid || ras_close_invalid)))
        else $error("push coincides with close");
    end
  end

endmodule
